// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped UART transmitter (TXDATA/STATUS registers) with a transmit FIFO.
// Define UART_TX_PARITY_EN to send an even-parity 8E1 frame; the default build sends 8N1.
module uart_tx_io #(
   parameter int BAUD_DIV   = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        IO_SEL,
   input  logic [3:0]  ADDR,
   input  logic [31:0] WDATA,
   input  logic [4:0]  WMASK,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [3:0]  ADDR_TXDATA = 4'b1000;
   localparam logic [3:0]  ADDR_STATUS = 4'b1001;
   localparam logic [15:0] BAUD_LOAD   = 16'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_FLAG = 1'b1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   localparam logic PARITY_FLAG = 1'b0;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state, state_d;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [15:0]   baud_cnt, baud_cnt_d;
   logic [2:0]    bit_cnt, bit_cnt_d;
   logic [7:0]    shift, shift_d;
   logic          tx_d;
   logic          full, empty, push_req, push, pop, ovf_evt, ovf_clr, baud_done;
   logic [3:0]    cnt_field;
   logic          unused_bits;
`ifdef UART_TX_PARITY_EN
   logic          par_bit, par_bit_d;
`endif

   assign full      = (count == CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign push_req  = IO_SEL & WMASK[0] & (ADDR == ADDR_TXDATA);
   // A full FIFO still accepts a write when the transmitter frees a slot in the same cycle.
   assign push      = push_req & (~full | pop);
   assign ovf_evt   = push_req & full & ~pop;
   assign ovf_clr   = IO_SEL & WMASK[0] & (ADDR == ADDR_STATUS) & WDATA[3];
   assign baud_done = (baud_cnt == '0);
   assign busy      = (state != IDLE) | ~empty;
   assign unused_bits = ^{WDATA[31:8], WDATA[7:4], WDATA[2:0], WMASK[4:1]};

   always_ff @(posedge CLK) begin
      if (push) fifo_mem[wr_ptr] <= WDATA[7:0];
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         if (ovf_evt)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   // Pop decisions use the registered count, so a byte written into an empty FIFO waits one cycle.
   always_comb begin
      state_d    = state;
      baud_cnt_d = baud_done ? baud_cnt : baud_cnt - 16'd1;
      bit_cnt_d  = bit_cnt;
      shift_d    = shift;
      tx_d       = tx;
      pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit_d  = par_bit;
`endif
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_d    = fifo_mem[rd_ptr];
               state_d    = START;
               baud_cnt_d = BAUD_LOAD;
               tx_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
               par_bit_d  = ^fifo_mem[rd_ptr];
`endif
            end
         end
         START: begin
            if (baud_done) begin
               state_d    = DATA;
               baud_cnt_d = BAUD_LOAD;
               bit_cnt_d  = 3'd0;
               tx_d       = shift[0];
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_cnt_d = BAUD_LOAD;
               if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_bit;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_cnt_d = bit_cnt + 3'd1;
                  shift_d   = {1'b0, shift[7:1]};
                  tx_d      = shift[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_done) begin
               state_d    = STOP;
               baud_cnt_d = BAUD_LOAD;
               tx_d       = 1'b1;
            end
         end
`endif
         STOP: begin
            if (baud_done) begin
               if (!empty) begin
                  pop        = 1'b1;
                  shift_d    = fifo_mem[rd_ptr];
                  state_d    = START;
                  baud_cnt_d = BAUD_LOAD;
                  tx_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
                  par_bit_d  = ^fifo_mem[rd_ptr];
`endif
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_d;
         baud_cnt <= baud_cnt_d;
         bit_cnt  <= bit_cnt_d;
         tx       <= tx_d;
      end
   end

   always_ff @(posedge CLK) begin
      shift <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_bit <= par_bit_d;
`endif
   end

   // STATUS count field saturates at 15 for deep FIFOs.
   always_comb begin
      cnt_field = (32'(count) > 32'd15) ? 4'hF : 4'(count);
      rdata     = '0;
      if (IO_SEL && (ADDR == ADDR_STATUS))
         rdata = {23'b0, PARITY_FLAG, cnt_field, overflow, (state != IDLE), empty, full};
   end

endmodule

// File: tb/tb_uart_tx_io.sv
// Directed bench for uart_tx_io: register map, framing, FIFO flow control, overflow and reset.
module tb_uart_tx_io;
   localparam int B = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
   localparam int FR  = 11;
`else
   localparam bit PAR = 1'b0;
   localparam int FR  = 10;
`endif
   localparam logic [31:0] PB   = PAR ? 32'h100 : 32'h0;
   localparam logic [3:0]  A_TX = 4'h8;
   localparam logic [3:0]  A_ST = 4'h9;

   logic        CLK = 1'b0;
   logic        RESET_N, IO_SEL, tx, busy;
   logic [3:0]  ADDR;
   logic [31:0] WDATA, rdata;
   logic [4:0]  WMASK;
   int          cyc = 0;
   int          checks = 0, passes = 0, fails = 0;
   logic [7:0]  sb [$];
   logic        mon_en = 1'b1;

   uart_tx_io #(.BAUD_DIV(B), .FIFO_DEPTH(8)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .IO_SEL(IO_SEL), .ADDR(ADDR), .WDATA(WDATA),
      .WMASK(WMASK), .rdata(rdata), .tx(tx), .busy(busy)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic strobe);
      IO_SEL = 1'b1; ADDR = a; WDATA = d; WMASK = {4'b0, strobe};
      @(posedge CLK); #1;
      IO_SEL = 1'b0; ADDR = 4'h0; WDATA = 32'h0; WMASK = 5'h0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      sb.push_back(b);
      bus_write(A_TX, {24'h0, b}, 1'b1);
   endtask

   task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      IO_SEL = 1'b1; ADDR = a; WMASK = 5'h0;
      #1;
      check(tag, rdata, exp);
      IO_SEL = 1'b0; ADDR = 4'h0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge CLK); #1;
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (PAR && k == 9) return ^d;
      return 1'b1;
   endfunction

   // Serial monitor: decodes frames mid-bit and checks them against the scoreboard.
   initial begin : monitor
      logic [7:0] d, e;
      logic st, sbit, pbit, prev_tx;
      prev_tx = 1'b1;
      forever begin
         @(negedge CLK);
         if (mon_en && prev_tx === 1'b1 && tx === 1'b0) begin
            repeat (B/2) @(negedge CLK);
            st = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (B) @(negedge CLK);
               d[i] = tx;
            end
            pbit = 1'b0;
`ifdef UART_TX_PARITY_EN
            repeat (B) @(negedge CLK);
            pbit = tx;
`endif
            repeat (B) @(negedge CLK);
            sbit = tx;
            if (mon_en) begin
               check("mon_start_bit", {31'b0, st}, 32'h0);
               check("mon_stop_bit", {31'b0, sbit}, 32'h1);
               check("mon_frame_expected", {31'b0, (sb.size() != 0)}, 32'h1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check("mon_data", {24'h0, d}, {24'h0, e});
`ifdef UART_TX_PARITY_EN
                  check("mon_parity", {31'b0, pbit}, {31'b0, ^e});
`endif
               end
            end
         end
         prev_tx = tx;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, n;
      logic seen;
      IO_SEL = 1'b0; ADDR = 4'h0; WDATA = 32'h0; WMASK = 5'h0; RESET_N = 1'b0;
      repeat (3) @(posedge CLK); #1;
      check("rst_tx", {31'b0, tx}, 32'h1);
      check("rst_busy", {31'b0, busy}, 32'h0);
      read_chk("rst_status", A_ST, PB | 32'h02);
      RESET_N = 1'b1;
      @(posedge CLK); #1;

      // Unmapped reads and stores
      read_chk("rd_io10", 4'h4, 32'h0);
      read_chk("rd_io04", 4'h1, 32'h0);
      ADDR = A_ST; IO_SEL = 1'b0; #1;
      check("rd_status_nosel", rdata, 32'h0);
      ADDR = 4'h0;
      bus_write(4'h1, 32'h5A, 1'b1);
      bus_write(A_TX, 32'h5B, 1'b0);
      repeat (3) @(posedge CLK); #1;
      read_chk("no_push_status", A_ST, PB | 32'h02);
      check("no_push_tx", {31'b0, tx}, 32'h1);

      // Single frame, bit timing
      push_byte(8'h55);
      t = cyc;
      check("t1_tx_at_push", {31'b0, tx}, 32'h1);
      wait_until(t + 1);
      check("t1_start_latency", {31'b0, tx}, 32'h0);
      for (int k = 0; k < FR; k++) begin
         wait_until(t + 1 + k*B + B/2);
         check($sformatf("t1_bit%0d", k), {31'b0, tx}, {31'b0, exp_bit(8'h55, k)});
      end
      wait_until(t + FR*B);
      check("t1_busy_last", {31'b0, busy}, 32'h1);
      wait_until(t + 1 + FR*B);
      check("t1_idle_tx", {31'b0, tx}, 32'h1);
      check("t1_idle_busy", {31'b0, busy}, 32'h0);

      // Back-to-back frames
      push_byte(8'h01);
      t = cyc;
      push_byte(8'h02);
      push_byte(8'h03);
      wait_until(t + 1 + FR*B);
      check("t2_no_gap1", {31'b0, tx}, 32'h0);
      wait_until(t + 1 + 2*FR*B);
      check("t2_no_gap2", {31'b0, tx}, 32'h0);
      wait_until(t + 3*FR*B);
      check("t2_busy_end", {31'b0, busy}, 32'h1);
      wait_until(t + 1 + 3*FR*B);
      check("t2_done_busy", {31'b0, busy}, 32'h0);
      check("t2_done_tx", {31'b0, tx}, 32'h1);
      check("t2_sb_empty", sb.size(), 32'h0);

      // FIFO full, overflow, simultaneous push/pop
      push_byte(8'h10);
      t = cyc;
      for (int i = 1; i < 9; i++) push_byte(8'h10 + 8'(i));
      bus_write(A_TX, 32'hEE, 1'b1);
      read_chk("t3_overflow_full", A_ST, PB | 32'h8D);
      bus_write(A_ST, 32'h8, 1'b1);
      read_chk("t3_ovf_cleared", A_ST, PB | 32'h85);
      wait_until(t + FR*B);
      push_byte(8'h19);
      read_chk("t3_full_pop_accept", A_ST, PB | 32'h85);
      bus_write(A_TX, 32'hEF, 1'b1);
      read_chk("t3_overflow_again", A_ST, PB | 32'h8D);
      bus_write(A_ST, 32'h8, 1'b1);
      read_chk("t3_ovf_cleared2", A_ST, PB | 32'h85);
      n = 0;
      while ((busy !== 1'b0 || sb.size() != 0) && n < 2000) begin
         @(posedge CLK); #1;
         n++;
      end
      check("t3_drain_sb", sb.size(), 32'h0);
      check("t3_drain_busy", {31'b0, busy}, 32'h0);

`ifdef UART_TX_PARITY_EN
      push_byte(8'h07);
      t = cyc;
      wait_until(t + 1 + 9*B + B/2);
      check("par_07_bit", {31'b0, tx}, 32'h1);
      wait_until(t + 1 + 11*B);
      check("par_07_frame44", {31'b0, busy}, 32'h0);
      push_byte(8'h03);
      t = cyc;
      wait_until(t + 1 + 9*B + B/2);
      check("par_03_bit", {31'b0, tx}, 32'h0);
      wait_until(t + 1 + 11*B);
`endif

      // Reset in the middle of a frame with bytes queued
      mon_en = 1'b0;
      bus_write(A_TX, 32'hA5, 1'b1);
      t = cyc;
      bus_write(A_TX, 32'h01, 1'b1);
      bus_write(A_TX, 32'h02, 1'b1);
      bus_write(A_TX, 32'h03, 1'b1);
      wait_until(t + 12);
      read_chk("t4_status_queued", A_ST, PB | 32'h34);
      #2 RESET_N = 1'b0;
      #1;
      check("t4_rst_tx", {31'b0, tx}, 32'h1);
      check("t4_rst_busy", {31'b0, busy}, 32'h0);
      read_chk("t4_rst_status", A_ST, PB | 32'h02);
      @(posedge CLK); @(posedge CLK); #1;
      RESET_N = 1'b1;
      seen = 1'b0;
      repeat (60) begin
         @(posedge CLK); #1;
         if (tx !== 1'b1 || busy !== 1'b0) seen = 1'b1;
      end
      check("t4_no_frames_after_reset", {31'b0, seen}, 32'h0);
      read_chk("t4_status_after", A_ST, PB | 32'h02);
      mon_en = 1'b1;

      check("final_sb_empty", sb.size(), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
